// File: rtl/cpu_ram_if.sv
// CPU RAM port and boot-loader port bundle for cpu_ram_responder.
interface cpu_ram_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr_toRAM;
  logic [DATA_W-1:0] data_toRAM;
  logic              wrEn;
  logic [DATA_W-1:0] data_fromRAM;

  // Loader handshake: a word transfers on a rising clk edge where load_valid
  // and load_ready are both high; load_ready never depends on load_valid, and
  // the loader holds addr/data/last stable while load_valid waits for ready.
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  modport master (
    output addr_toRAM, data_toRAM, wrEn, load_valid, load_addr, load_data, load_last,
    input  data_fromRAM, load_ready
  );

  modport slave (
    input  addr_toRAM, data_toRAM, wrEn, load_valid, load_addr, load_data, load_last,
    output data_fromRAM, load_ready
  );
endinterface

// File: rtl/cpu_ram_responder.sv
// 2^ADDR_W x DATA_W RAM with registered one-cycle CPU read and a boot loader
// that holds the CPU in reset. Define RAM_WRPROT_EN to protect addresses below PROT_TOP.
module cpu_ram_responder #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int PROT_TOP = 16
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ram_if.slave   bus,
  output logic       cpu_rst,
  output logic       wp_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

`ifdef RAM_WRPROT_EN
  localparam bit WRPROT = 1'b1;
`else
  localparam bit WRPROT = 1'b0;
`endif

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic              run;
  logic              load_fire;
  logic              prot_hit;
  logic              cpu_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = LOAD;
      LOAD:    if (load_fire && bus.load_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    bus.load_ready = (state == LOAD);
    cpu_rst        = (state != RUN);
    state_dbg      = state;
  end

  assign run       = (state == RUN);
  assign load_fire = bus.load_valid && bus.load_ready;
  assign prot_hit  = WRPROT && run && bus.wrEn && (int'(bus.addr_toRAM) < PROT_TOP);
  assign cpu_wr    = run && bus.wrEn && !prot_hit;

  // Loader and CPU writes never coincide since they live in different states.
  always_comb begin
    mem_we  = 1'b0;
    wr_addr = bus.load_addr;
    wr_data = bus.load_data;
    if (load_fire) begin
      mem_we = 1'b1;
    end else if (cpu_wr) begin
      mem_we  = 1'b1;
      wr_addr = bus.addr_toRAM;
      wr_data = bus.data_toRAM;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  // Read-first: the read register samples the array before the same-edge write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     bus.data_fromRAM <= '0;
    else if (run) bus.data_fromRAM <= mem[bus.addr_toRAM];
    else          bus.data_fromRAM <= '0;
  end

`ifdef RAM_WRPROT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          wp_err <= 1'b0;
    else if (prot_hit) wp_err <= 1'b1;
  end
`else
  assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Scoreboard bench for cpu_ram_responder: randomized loader/CPU traffic checked
// against an associative-array memory model and a three-phase boot model.
module tb_cpu_ram_responder;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int EW = DW + 4;
`ifdef RAM_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int PROT_TOP = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic       cpu_rst;
  logic       wp_err;
  logic [1:0] state_dbg;

  cpu_ram_responder #(.ADDR_W(AW), .DATA_W(DW), .PROT_TOP(PROT_TOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .wp_err    (wp_err),
    .state_dbg (state_dbg)
  );

  // reference model: 0 = boot, 1 = loading, 2 = running
  logic [DW-1:0] ref_mem [int];
  int            mode   = 0;
  bit            ref_wp = 1'b0;

  // scoreboard entry: {data_known, wp_err, load_ready, cpu_rst, data_fromRAM}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_now(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic apply(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit ll, input bit we, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd);
    logic [DW-1:0] ed;
    bit            known;
    int            nm;
    bus.load_valid = lv;
    bus.load_addr  = la;
    bus.load_data  = ld;
    bus.load_last  = ll;
    bus.wrEn       = we;
    bus.addr_toRAM = ca;
    bus.data_toRAM = cd;
    ed    = '0;
    known = 1'b1;
    nm    = mode;
    if (mode == 0) begin
      nm = 1;
    end else if (mode == 1) begin
      if (lv) begin
        ref_mem[int'(la)] = ld;
        if (ll) nm = 2;
      end
    end else begin
      known = ref_mem.exists(int'(ca));
      if (known) ed = ref_mem[int'(ca)];
      if (we) begin
        if (PROT && int'(ca) < PROT_TOP) ref_wp = 1'b1;
        else                             ref_mem[int'(ca)] = cd;
      end
    end
    mode = nm;
    exp_q.push_back({known, ref_wp, (mode == 1), (mode != 2), ed});
  endtask

  // driver tasks
  task automatic step(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input bit ll, input bit we, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd);
    @(negedge clk);
    apply(lv, la, ld, ll, we, ca, cd);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit last);
    step(1'b1, a, d, last, 1'b0, '0, '0);
  endtask

  task automatic cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, '0, '0, 1'b0, we, a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.load_valid = 1'b0;
    bus.wrEn       = 1'b0;
    #1;
    check_now("rst_data", bus.data_fromRAM, '0);
    check_now("rst_cpu_rst", {15'b0, cpu_rst}, 16'd1);
    check_now("rst_load_ready", {15'b0, bus.load_ready}, 16'd0);
    check_now("rst_wp_err", {15'b0, wp_err}, 16'd0);
    mode   = 0;
    ref_wp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // monitor: one prediction per driven cycle, compared just after the edge
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {e[EW-1], wp_err, bus.load_ready, cpu_rst, bus.data_fromRAM};
        if (!e[EW-1]) begin
          got[DW-1:0] = '0;
          e[DW-1:0]   = '0;
        end
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL resp @%0t: got wp/rdy/crst/data %b%b%b/%h expected %b%b%b/%h",
                   $time, got[DW+2], got[DW+1], got[DW], got[DW-1:0],
                   e[DW+2], e[DW+1], e[DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.wrEn       = 1'b0;
    bus.addr_toRAM = '0;
    bus.data_toRAM = '0;

    do_reset();

    // boot load, with CPU writes and idle gaps mixed in
    load(13'h0000, 16'hA005, 1'b0);
    cpu(1'b1, 13'h0009, 16'h7777);
    load(13'h0009, 16'h1111, 1'b0);
    load(13'h0007, 16'h5A5A, 1'b0);
    load(13'h0003, 16'h3333, 1'b0);
    load(13'h0010, 16'h0F0F, 1'b0);
    load(13'h0020, 16'h0001, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, '0, '0, 1'b1, 1'b1, AW'($urandom), DW'($urandom));
      else
        load(AW'($urandom_range(64, 127)), DW'($urandom), 1'b0);
    end
    load(13'h0005, 16'h1234, 1'b1);

    // directed RUN traffic
    cpu(1'b0, 13'h0005, '0);
    cpu(1'b0, 13'h0000, '0);
    cpu(1'b0, 13'h0005, '0);
    cpu(1'b1, 13'h0100, 16'hBEEF);
    cpu(1'b0, 13'h0100, '0);
    cpu(1'b1, 13'h0020, 16'h0002);
    cpu(1'b0, 13'h0020, '0);
    step(1'b1, 13'h0007, 16'hFFFF, 1'b1, 1'b0, 13'h0007, '0);
    cpu(1'b0, 13'h0007, '0);
    cpu(1'b0, 13'h0009, '0);
    cpu(1'b1, 13'h0003, 16'h5555);
    cpu(1'b0, 13'h0003, '0);
    cpu(1'b1, 13'h0010, 16'hCAFE);
    cpu(1'b0, 13'h0010, '0);
    cpu(1'b0, 13'h1FFF, '0);

    // randomized RUN traffic
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 127));
      step(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), a, DW'($urandom));
    end

    // reset mid-RUN, then mid-LOAD; memory contents must survive both
    do_reset();
    load(13'h0300, 16'hABCD, 1'b0);
    do_reset();
    cpu(1'b1, 13'h0301, 16'h9999);
    load(13'h0301, 16'h4321, 1'b1);
    cpu(1'b0, 13'h0301, '0);
    cpu(1'b0, 13'h0300, '0);
    cpu(1'b0, 13'h0100, '0);
    cpu(1'b0, 13'h0003, '0);
    cpu(1'b0, 13'h0000, '0);

    @(negedge clk);
    bus.wrEn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_ram_responder.md
# cpu_ram_responder

Memory-side responder for the 16-bit accumulator CPU's RAM port. Holds an 8K x 16 word store, answers the CPU's combinational address/write-enable/data outputs with a registered one-cycle read, and carries a boot-load port that fills memory while holding the CPU in reset. It sits between the CPU and the board-level loader in the top-level wrapper.

## Interface

- ADDR_W, 13, address width; depth = 2^ADDR_W words
- DATA_W, 16, word width
- PROT_TOP, 16, first writable address when write protection is compiled in; addresses 0..PROT_TOP-1 are protected
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- addr_toRAM  input  ADDR_W  CPU address, combinational from CPU
- data_toRAM  input  DATA_W  CPU write data
- wrEn  input  1  CPU write strobe, sampled on clk
- data_fromRAM  output  DATA_W  registered read data to CPU
- load_valid  input  1  loader word available
- load_ready  output  1  responder accepts loader word this cycle
- load_addr  input  ADDR_W  loader target address
- load_data  input  DATA_W  loader word
- load_last  input  1  qualifies final loader word
- cpu_rst  output  1  active-high reset to the CPU
- wp_err  output  1  sticky protected-write flag

## Operation

- FSM states: BOOT, LOAD, RUN.
- rst low (async): state=BOOT, data_fromRAM=0, load_ready=0, cpu_rst=1, wp_err=0. Memory array contents are not reset.
- BOOT: one cycle after rst release -> LOAD. cpu_rst=1, load_ready=0.
- LOAD: load_ready=1, cpu_rst=1. On load_valid&&load_ready: mem[load_addr]<=load_data. If load_last also set -> RUN next cycle. CPU port ignored (wrEn has no effect), data_fromRAM held at 0.
- RUN: load_ready=0, load_valid ignored, cpu_rst=0. Every cycle data_fromRAM<=mem[addr_toRAM]. If wrEn: mem[addr_toRAM]<=data_toRAM (subject to protection).
- Read-during-write same address: read-first; data_fromRAM returns the old word, new word visible on the following read.
- Addresses wrap naturally; no out-of-range case exists since depth = 2^ADDR_W.
- Reset mid-LOAD or mid-RUN: returns to BOOT, load restarts; already-written words remain.
- No return from RUN to LOAD except through rst.

## Timing

- Read latency: exactly 1 clk. Address presented in cycle N -> data_fromRAM valid after edge N+1, held until next edge. Matches CPU fetch/operand states that present address then consume data next state.
- Write: committed on the edge where wrEn=1; single-cycle, no acknowledge.
- Loader: one word per cycle max; load_ready is a state decode (no dependence on load_valid).
- cpu_rst deasserts on the same edge that enters RUN; CPU's first fetch (address 0) returns data one cycle later.
- The word accepted with load_last is readable in the first RUN cycle.

## Configuration

- RAM_WRPROT_EN defined: in RUN, wrEn with addr_toRAM < PROT_TOP does not modify memory and sets wp_err (sticky until rst). Loader writes are never protected. Reads unaffected.
- RAM_WRPROT_EN undefined: all CPU writes commit; PROT_TOP unused; wp_err tied 0.

## Test plan

- Reset: assert rst low mid-RUN -> data_fromRAM=0, cpu_rst=1, load_ready=0 immediately; one cycle after release load_ready=1.
- Boot load: load words 0xA005@0, 0x1234@5, last at address 5 -> RUN next cycle, cpu_rst=0; address 0 then 5 returns 0xA005 then 0x1234, each one cycle after address.
- CPU write/read: RUN, wrEn=1 addr 0x0100 data 0xBEEF; next cycle addr 0x0100 read -> 0xBEEF one cycle later.
- Read-during-write: mem[0x20]=0x0001, wrEn addr 0x20 data 0x0002 -> data_fromRAM=0x0001 that edge, 0x0002 on following read.
- Loader ignored in RUN / CPU ignored in LOAD: load_valid with 0xFFFF@7 in RUN -> mem[7] unchanged; wrEn in LOAD -> no write, data_fromRAM=0.
- With RAM_WRPROT_EN, PROT_TOP=16: wrEn addr 3 data 0x5555 -> mem[3] unchanged, wp_err=1 and stays 1; write addr 16 commits. Without macro, same write to addr 3 commits, wp_err=0.
